// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority arbiter merging NCH CPU channels onto one split-handshake memory port
// Optional kseg0/kseg1 to physical address folding on mem_addr: define ARB_KSEG_MAP_EN.
module mem_port_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH*DW/8-1:0]   ch_wen,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH*DW-1:0]     ch_wdata,
  output logic [NCH*DW-1:0]     ch_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic [DW/8-1:0]       mem_wen,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DW-1:0]         mem_rdata
);
  localparam int BW = DW / 8;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [NCH-1:0]    served_q, served_d;
  logic              mem_req_q, mem_req_d;
  logic [BW-1:0]     wen_q, wen_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NCH*DW-1:0] rdata_q, rdata_d;

  logic [NCH-1:0]    pending;
  logic [CW-1:0]     pick;
  logic              pick_vld;
  logic              done;

  assign pending = ch_en & ~served_q;
  // An outstanding access keeps the stall up even if its channel was flushed,
  // so served is never cleared underneath it and the group cannot re-issue.
  assign stall   = (|pending) | (state_q != S_IDLE);

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick     = CW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign done = ((state_q == S_RESP) && mem_data_ok) ||
                ((state_q == S_REQ) && mem_addr_ok && mem_data_ok);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    served_d = served_q;
    rdata_d  = rdata_q;

    if (!stall) begin
      served_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          cur_d   = pick;
          wen_d   = ch_wen[pick*BW +: BW];
          addr_d  = ch_addr[pick*AW +: AW];
          wdata_d = ch_wdata[pick*DW +: DW];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_addr_ok) begin
          state_d = mem_data_ok ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (mem_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      served_d = served_q | (NCH'(1) << cur_q);
      rdata_d[cur_q*DW +: DW] = mem_rdata;
    end

    mem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      served_q  <= '0;
      mem_req_q <= 1'b0;
      wen_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      served_q  <= served_d;
      mem_req_q <= mem_req_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign ch_rdata  = rdata_q;

`ifdef ARB_KSEG_MAP_EN
  generate
    if (AW == 32) begin : g_kseg
      // 0x8000_0000..0xBFFF_FFFF (top bits 10) fold onto physical by clearing [31:29]
      assign mem_addr = (addr_q[AW-1 -: 2] == 2'b10) ? {3'b000, addr_q[AW-4:0]} : addr_q;
    end else begin : g_nokseg
      assign mem_addr = addr_q;
    end
  endgenerate
`else
  assign mem_addr = addr_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a delay-programmable memory model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_en;
  logic [NCH*4-1:0]  ch_wen;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH*DW-1:0] ch_rdata;
  logic              stall;
  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DW-1:0]     mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .stall(stall),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wen;
  } acc_t;

  acc_t sb_q[$];
  acc_t done_q[$];
  acc_t cur_acc;

  int n_checks = 0;
  int n_errors = 0;
  int a_dly = 0;
  int d_dly = 0;
  int phase = 0;
  int wcnt = 0;
  int dcnt = 0;
  int req_cnt = 0;
  bit mem_auto = 1'b1;
  logic [31:0] held_addr;
  logic [31:0] held_wdata;
  logic [3:0]  held_wen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] phys(input logic [31:0] a);
`ifdef ARB_KSEG_MAP_EN
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  // memory model: decides handshakes at negedge for the following rising edge
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (rst) begin
          phase = 0;
        end else if (phase == 2) begin
          if (dcnt == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = cur_acc.rdata;
            done_q.push_back(cur_acc);
            phase = 0;
          end else begin
            dcnt--;
          end
        end else begin
          if (phase == 0 && mem_req === 1'b1) begin
            req_cnt++;
            if (sb_q.size() == 0) begin
              check_eq("unexpected_req", 64'd1, 64'd0);
            end else begin
              cur_acc = sb_q.pop_front();
              check_eq("req_addr", mem_addr, phys(cur_acc.addr));
              check_eq("req_wen", mem_wen, cur_acc.wen);
              check_eq("req_wdata", mem_wdata, cur_acc.wdata);
            end
            held_addr  = mem_addr;
            held_wen   = mem_wen;
            held_wdata = mem_wdata;
            wcnt  = a_dly;
            phase = 1;
          end else if (phase == 1) begin
            check_eq("held_req", mem_req, 1'b1);
            check_eq("held_addr", mem_addr, held_addr);
            check_eq("held_wen", mem_wen, held_wen);
            check_eq("held_wdata", mem_wdata, held_wdata);
          end
          if (phase == 1) begin
            if (wcnt == 0) begin
              mem_addr_ok = 1'b1;
              dcnt  = d_dly;
              phase = 2;
            end else begin
              wcnt--;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic add_acc(input int ch, input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    acc_t e;
    e.ch = ch; e.addr = addr; e.wen = wen; e.wdata = wdata; e.rdata = rdata;
    ch_addr[ch*AW +: AW] = addr;
    ch_wen[ch*4 +: 4]    = wen;
    ch_wdata[ch*DW +: DW] = wdata;
    sb_q.push_back(e);
  endtask

  task automatic check_done(input string tag);
    acc_t e;
    while (done_q.size() > 0) begin
      e = done_q.pop_front();
      if (e.wen == 4'd0) check_eq({tag, "_rdata"}, ch_rdata[e.ch*DW +: DW], e.rdata);
    end
  endtask

  task automatic run_group(input string tag, input int exp_stall, input int exp_reqs);
    int cnt;
    int r0;
    cnt = 0;
    r0 = req_cnt;
    #1;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check_eq({tag, "_stall_cycles"}, cnt, exp_stall);
    check_eq({tag, "_reqs"}, req_cnt - r0, exp_reqs);
    check_done(tag);
    ch_en = '0;
    tick();
  endtask

  logic [31:0] kseg_tab [4];

  initial begin
    int cnt;
    int r0;
    rst = 1'b1; ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
    kseg_tab[0] = 32'hBFAF_F000; kseg_tab[1] = 32'h0040_0000;
    kseg_tab[2] = 32'h8000_0000; kseg_tab[3] = 32'hC000_0000;
    repeat (3) tick();
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_wen", mem_wen, 4'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_ch_rdata", ch_rdata, 64'd0);
    check_eq("rst_stall_idle", stall, 1'b0);
    ch_en = 2'b10;
    #1 check_eq("rst_stall_follows_en", stall, 1'b1);
    ch_en = '0;
    rst = 1'b0;
    tick();

    // single zero-wait read
    add_acc(0, 32'h0000_1000, 4'h0, 32'hAAAA_0000, 32'hDEAD_BEEF);
    ch_en = 2'b01;
    run_group("single", 3, 1);

    // both channels in one group: ch0 read first, then ch1 write
    add_acc(0, 32'h0000_2000, 4'h0, 32'h0, 32'h0BAD_F00D);
    add_acc(1, 32'h0000_3000, 4'hF, 32'h1234_5678, 32'h0);
    ch_en = 2'b11;
    run_group("dual", 6, 2);

    // wait states on both handshakes
    a_dly = 4; d_dly = 2;
    add_acc(1, 32'h0000_4000, 4'h0, 32'h0, 32'hCAFE_0001);
    ch_en = 2'b10;
    run_group("wait_rd", 9, 1);
    add_acc(0, 32'h0000_5000, 4'h3, 32'h5555_AAAA, 32'h0);
    ch_en = 2'b01;
    run_group("wait_wr", 9, 1);
    d_dly = 0;

    // flush of ch1 while its request waits for acceptance
    add_acc(1, 32'h0000_6000, 4'h0, 32'h0, 32'h7777_0001);
    r0 = req_cnt;
    cnt = 0;
    ch_en = 2'b10;
    #1;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 2) begin
        check_eq("flush_req_up", mem_req, 1'b1);
        ch_en = 2'b00;
        #1 check_eq("flush_stall_hold", stall, 1'b1);
      end
      tick();
    end
    check_eq("flush_stall_cycles", cnt, 7);
    repeat (6) tick();
    check_eq("flush_reqs", req_cnt - r0, 1);
    check_eq("flush_stall_low", stall, 1'b0);
    check_done("flush");
    a_dly = 0;

    // address translation table
    for (int i = 0; i < 4; i++) begin
      add_acc(0, kseg_tab[i], 4'h0, 32'h0, 32'h1000 + i);
      ch_en = 2'b01;
      run_group("kseg", 3, 1);
    end

    // reset while in RESP
    d_dly = 5;
    add_acc(0, 32'h0000_7000, 4'h0, 32'h0, 32'h9999_0000);
    ch_en = 2'b01;
    cnt = 0;
    while (phase != 2 && cnt < 50) begin
      cnt++;
      tick();
    end
    check_eq("rst_reach_resp", phase, 2);
    mem_auto = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    phase = 0;
    rst = 1'b1;
    ch_en = '0;
    tick();
    check_eq("midrst_mem_req", mem_req, 1'b0);
    check_eq("midrst_ch_rdata", ch_rdata, 64'd0);
    check_eq("midrst_stall", stall, 1'b0);
    check_eq("midrst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_data_ok = 1'b0;
    check_eq("late_dok_rdata", ch_rdata, 64'd0);
    check_eq("late_dok_req", mem_req, 1'b0);
    check_eq("late_dok_stall", stall, 1'b0);
    mem_auto = 1'b1;
    d_dly = 0;
    add_acc(1, 32'h0000_8000, 4'h0, 32'h0, 32'h4242_4242);
    ch_en = 2'b10;
    run_group("post_rst", 3, 1);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
